// File: rtl/temp_pkg.sv
// Shared types and default thresholds for the multi-channel temperature
// state monitor.
//   estado_t    : per-channel state, encoded NORMAL=00 BAJO=01 ALTO=10 ALERTA=11
//   DEF_*       : default parameter values used by estado_temp_multi
package temp_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        BAJO   = 2'b01,
        ALTO   = 2'b10,
        ALERTA = 2'b11
    } estado_t;

    localparam int DEF_NCH       = 4;
    localparam int DEF_W         = 11;
    localparam int DEF_TEMP_BAJO = 180;
    localparam int DEF_TEMP_ALTO = 250;
    localparam int DEF_HYST      = 5;
    localparam int DEF_N         = 5;

endpackage

// File: rtl/estado_temp_canal.sv
// One temperature channel: classifies each accepted sample, runs the
// NORMAL/BAJO/ALTO/ALERTA state machine with a persistence counter, drives the
// heater/fan commands and keeps the sticky alert flag.
// Ports:
//   clk_i, arst_ni  : clock, asynchronous active-low reset
//   valid_i, temp_i : sample strobe and signed sample
//   ack_i           : acknowledge for the sticky alert flag
//   estado_o        : current state
//   alerta_o        : sticky alert flag
//   calefactor_o    : heater command
//   ventilador_o    : fan command
module estado_temp_canal
    import temp_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int TEMP_BAJO = DEF_TEMP_BAJO,
    parameter int TEMP_ALTO = DEF_TEMP_ALTO,
    parameter int HYST      = DEF_HYST,
    parameter int N         = DEF_N
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                valid_i,
    input  logic signed [W-1:0] temp_i,
    input  logic                ack_i,
    output estado_t             estado_o,
    output logic                alerta_o,
    output logic                calefactor_o,
    output logic                ventilador_o
);

    localparam int CW = $clog2(N + 1);

    localparam logic signed [W-1:0] T_BAJO  = W'(TEMP_BAJO);
    localparam logic signed [W-1:0] T_ALTO  = W'(TEMP_ALTO);
    localparam logic signed [W-1:0] BAND_LO = W'(TEMP_BAJO + HYST);
    localparam logic signed [W-1:0] BAND_HI = W'(TEMP_ALTO - HYST);
    localparam logic [CW-1:0]       CNT_N   = CW'(N);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          alerta_q, alerta_d;
    logic          cal_q, cal_d;
    logic          ven_q, ven_d;

    logic es_bajo, es_alto, en_banda;

    // Samples that are neither low, high nor in-band fall in a hysteresis zone
    always_comb begin
        es_bajo  = (temp_i < T_BAJO);
        es_alto  = (temp_i > T_ALTO);
        en_banda = (temp_i >= BAND_LO) && (temp_i <= BAND_HI);
    end

    assign cnt_inc = (cnt_q >= CNT_N) ? CNT_N : cnt_q + 1'b1;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        cal_d    = cal_q;
        ven_d    = ven_q;
        alerta_d = alerta_q;

        case (estado_q)
            NORMAL: begin
                if (valid_i) begin
                    if (es_bajo) begin
                        estado_d = BAJO;
                        cnt_d    = CW'(1);
                    end else if (es_alto) begin
                        estado_d = ALTO;
                        cnt_d    = CW'(1);
                    end else begin
                        cnt_d    = '0;
                    end
                end
            end
            BAJO: begin
                if (valid_i) begin
                    if (es_bajo) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_N) estado_d = ALERTA;
                    end else if (es_alto) begin
                        estado_d = ALTO;
                        cnt_d    = CW'(1);
                    end else if (en_banda) begin
                        estado_d = NORMAL;
                        cnt_d    = '0;
                    end
                end
            end
            ALTO: begin
                if (valid_i) begin
                    if (es_alto) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_N) estado_d = ALERTA;
                    end else if (es_bajo) begin
                        estado_d = BAJO;
                        cnt_d    = CW'(1);
                    end else if (en_banda) begin
                        estado_d = NORMAL;
                        cnt_d    = '0;
                    end
                end
            end
            ALERTA: begin
                if (valid_i && en_banda) begin
                    estado_d = NORMAL;
                    cnt_d    = '0;
                end
            end
            default: begin
                estado_d = NORMAL;
                cnt_d    = '0;
            end
        endcase

        // Actuators follow the sample direction only while (or when) in ALERTA;
        // a hysteresis-zone sample in ALERTA keeps the previous command.
        if (estado_d == ALERTA) begin
            if (valid_i && es_bajo) begin
                cal_d = 1'b1;
                ven_d = 1'b0;
            end else if (valid_i && es_alto) begin
                cal_d = 1'b0;
                ven_d = 1'b1;
            end
        end else begin
            cal_d = 1'b0;
            ven_d = 1'b0;
        end

        // Entry into ALERTA takes priority over an acknowledge on the same edge
        if (estado_d == ALERTA && estado_q != ALERTA) begin
            alerta_d = 1'b1;
        end else if (ack_i && estado_q != ALERTA) begin
            alerta_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            estado_q <= NORMAL;
            cnt_q    <= '0;
            alerta_q <= 1'b0;
            cal_q    <= 1'b0;
            ven_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            alerta_q <= alerta_d;
            cal_q    <= cal_d;
            ven_q    <= ven_d;
        end
    end

    assign estado_o     = estado_q;
    assign alerta_o     = alerta_q;
    assign calefactor_o = cal_q;
    assign ventilador_o = ven_q;

endmodule

// File: rtl/estado_temp_multi.sv
// Multi-channel temperature state monitor: NCH independent estado_temp_canal
// instances plus a registered global alert.
// Ports:
//   clk, arst_n    : clock, asynchronous active-low reset
//   temp_valid     : per-channel sample strobe
//   temp_in        : packed signed samples, channel i at [i*W +: W]
//   ack_alerta     : per-channel alert acknowledge
//   estado_actual  : packed 2-bit states, channel i at [2*i +: 2]
//   alerta         : per-channel sticky alert flags
//   calefactor     : per-channel heater commands
//   ventilador     : per-channel fan commands
//   alerta_global  : registered OR of alerta (one edge behind)
module estado_temp_multi
    import temp_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int W         = DEF_W,
    parameter int TEMP_BAJO = DEF_TEMP_BAJO,
    parameter int TEMP_ALTO = DEF_TEMP_ALTO,
    parameter int HYST      = DEF_HYST,
    parameter int N         = DEF_N
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [NCH-1:0]     temp_valid,
    input  logic [NCH*W-1:0]   temp_in,
    input  logic [NCH-1:0]     ack_alerta,
    output logic [2*NCH-1:0]   estado_actual,
    output logic [NCH-1:0]     alerta,
    output logic [NCH-1:0]     calefactor,
    output logic [NCH-1:0]     ventilador,
    output logic               alerta_global
);

    if (NCH < 1 || NCH > 8) begin : g_chk_nch
        $error("estado_temp_multi: NCH must be in 1..8");
    end
    if (N < 2 || N > 15) begin : g_chk_n
        $error("estado_temp_multi: N must be in 2..15");
    end
    if (TEMP_BAJO + HYST > TEMP_ALTO - HYST) begin : g_chk_band
        $error("estado_temp_multi: empty in-band range");
    end

    logic alerta_global_q, alerta_global_d;

    for (genvar i = 0; i < NCH; i++) begin : g_canal
        estado_t estado_c;

        estado_temp_canal #(
            .W         (W),
            .TEMP_BAJO (TEMP_BAJO),
            .TEMP_ALTO (TEMP_ALTO),
            .HYST      (HYST),
            .N         (N)
        ) u_canal (
            .clk_i        (clk),
            .arst_ni      (arst_n),
            .valid_i      (temp_valid[i]),
            .temp_i       (temp_in[i*W +: W]),
            .ack_i        (ack_alerta[i]),
            .estado_o     (estado_c),
            .alerta_o     (alerta[i]),
            .calefactor_o (calefactor[i]),
            .ventilador_o (ventilador[i])
        );

        assign estado_actual[2*i +: 2] = estado_c;
    end

    assign alerta_global_d = |alerta;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            alerta_global_q <= 1'b0;
        end else begin
            alerta_global_q <= alerta_global_d;
        end
    end

    assign alerta_global = alerta_global_q;

endmodule

// File: tb/tb_estado_temp_multi.sv
module tb_estado_temp_multi;

    localparam int NCH = 4;
    localparam int W   = 11;
    localparam int TB  = 180;
    localparam int TA  = 250;
    localparam int HY  = 5;
    localparam int NP  = 5;

    localparam int S_NORMAL = 0;
    localparam int S_BAJO   = 1;
    localparam int S_ALTO   = 2;
    localparam int S_ALERTA = 3;

    logic               clk;
    logic               arst_n;
    logic [NCH-1:0]     temp_valid;
    logic [NCH*W-1:0]   temp_in;
    logic [NCH-1:0]     ack_alerta;
    logic [2*NCH-1:0]   estado_actual;
    logic [NCH-1:0]     alerta;
    logic [NCH-1:0]     calefactor;
    logic [NCH-1:0]     ventilador;
    logic               alerta_global;

    int total;
    int bad;

    estado_temp_multi #(
        .NCH       (NCH),
        .W         (W),
        .TEMP_BAJO (TB),
        .TEMP_ALTO (TA),
        .HYST      (HY),
        .N         (NP)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .temp_valid    (temp_valid),
        .temp_in       (temp_in),
        .ack_alerta    (ack_alerta),
        .estado_actual (estado_actual),
        .alerta        (alerta),
        .calefactor    (calefactor),
        .ventilador    (ventilador),
        .alerta_global (alerta_global)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_st  [NCH];
    int m_cnt [NCH];
    bit m_cal [NCH];
    bit m_ven [NCH];
    bit m_al  [NCH];
    bit m_glob;

    // -1 low, +1 high, 0 in-band, 2 hysteresis zone
    function automatic int clase(int t);
        if (t < TB) return -1;
        if (t > TA) return 1;
        if (t >= TB + HY && t <= TA - HY) return 0;
        return 2;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_st[i] = S_NORMAL; m_cnt[i] = 0;
            m_cal[i] = 0; m_ven[i] = 0; m_al[i] = 0;
        end
        m_glob = 0;
    endfunction

    function automatic void model_edge();
        bit any;
        int old, t, c;
        any = 0;
        for (int i = 0; i < NCH; i++) any |= m_al[i];
        for (int i = 0; i < NCH; i++) begin
            old = m_st[i];
            if (temp_valid[i]) begin
                t = int'($signed(temp_in[i*W +: W]));
                c = clase(t);
                if (c == 0) begin
                    m_st[i] = S_NORMAL; m_cnt[i] = 0;
                end else if (old == S_ALERTA) begin
                    // stays in alert
                end else if (c == -1) begin
                    m_cnt[i] = (old == S_BAJO) ? m_cnt[i] + 1 : 1;
                    m_st[i]  = (m_cnt[i] >= NP) ? S_ALERTA : S_BAJO;
                end else if (c == 1) begin
                    m_cnt[i] = (old == S_ALTO) ? m_cnt[i] + 1 : 1;
                    m_st[i]  = (m_cnt[i] >= NP) ? S_ALERTA : S_ALTO;
                end else if (old == S_NORMAL) begin
                    m_cnt[i] = 0;
                end
                if (m_st[i] == S_ALERTA) begin
                    if (c == -1) begin m_cal[i] = 1; m_ven[i] = 0; end
                    else if (c == 1) begin m_cal[i] = 0; m_ven[i] = 1; end
                end else begin
                    m_cal[i] = 0; m_ven[i] = 0;
                end
            end
            if (m_st[i] == S_ALERTA && old != S_ALERTA) m_al[i] = 1;
            else if (ack_alerta[i] && old != S_ALERTA) m_al[i] = 0;
        end
        m_glob = any;
    endfunction

    function automatic logic [5*NCH:0] exp_vec();
        logic [5*NCH:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            r[2*i +: 2]    = 2'(m_st[i]);
            r[2*NCH + i]   = m_al[i];
            r[3*NCH + i]   = m_cal[i];
            r[4*NCH + i]   = m_ven[i];
        end
        r[5*NCH] = m_glob;
        return r;
    endfunction

    function automatic logic [5*NCH:0] obs_vec();
        return {alerta_global, ventilador, calefactor, alerta, estado_actual};
    endfunction

    function automatic logic [NCH*W-1:0] mk1(int ch, int val);
        logic [NCH*W-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*W +: W] = W'(200);
        r[ch*W +: W] = W'(val);
        return r;
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input logic [NCH-1:0] v, input logic [NCH*W-1:0] t,
                        input logic [NCH-1:0] a);
        temp_valid = v;
        temp_in    = t;
        ack_alerta = a;
        @(posedge clk);
        model_edge();
        #1;
        temp_valid = '0;
        ack_alerta = '0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        temp_valid = '0; ack_alerta = '0; temp_in = mk1(0, 200);
        do_reset();
        total++;
        if (obs_vec() !== '0) begin
            bad++; $display("FAIL reset: got %h want 0", obs_vec());
        end
    endtask

    task automatic test_ch0_alerta();
        int exp_seq [5] = '{S_BAJO, S_BAJO, S_BAJO, S_BAJO, S_ALERTA};
        for (int k = 0; k < 5; k++) begin
            step(NCH'(1), mk1(0, 170), '0);
            total++;
            if (estado_actual[1:0] !== 2'(exp_seq[k])) begin
                bad++; $display("FAIL ch0_state k=%0d: got %0d want %0d", k, estado_actual[1:0], exp_seq[k]);
            end
            total++;
            if (estado_actual[2*NCH-1:2] !== '0) begin
                bad++; $display("FAIL ch0_others k=%0d: got %h want 0", k, estado_actual);
            end
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL ch0_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        total++;
        if (calefactor[0] !== 1'b1 || ventilador[0] !== 1'b0 || alerta[0] !== 1'b1) begin
            bad++; $display("FAIL ch0_act: got cal=%b ven=%b al=%b want 1 0 1", calefactor[0], ventilador[0], alerta[0]);
        end
        step('0, mk1(0, 200), '0);
        total++;
        if (alerta_global !== 1'b1) begin
            bad++; $display("FAIL ch0_global: got %b want 1", alerta_global);
        end
    endtask

    task automatic test_ch0_release();
        step(NCH'(1), mk1(0, 182), '0);
        total++;
        if (estado_actual[1:0] !== 2'(S_ALERTA) || calefactor[0] !== 1'b1) begin
            bad++; $display("FAIL rel_hold: got st=%0d cal=%b want 3 1", estado_actual[1:0], calefactor[0]);
        end
        step(NCH'(1), mk1(0, 200), '0);
        total++;
        if (estado_actual[1:0] !== 2'(S_NORMAL) || calefactor[0] !== 1'b0 || ventilador[0] !== 1'b0) begin
            bad++; $display("FAIL rel_normal: got st=%0d cal=%b ven=%b want 0 0 0", estado_actual[1:0], calefactor[0], ventilador[0]);
        end
        repeat (3) step('0, mk1(0, 200), '0);
        total++;
        if (alerta[0] !== 1'b1) begin
            bad++; $display("FAIL rel_sticky: got %b want 1", alerta[0]);
        end
        step('0, mk1(0, 200), NCH'(1));
        total++;
        if (alerta[0] !== 1'b0 || alerta_global !== 1'b1) begin
            bad++; $display("FAIL rel_ack: got al=%b glob=%b want 0 1", alerta[0], alerta_global);
        end
        step('0, mk1(0, 200), '0);
        total++;
        if (obs_vec() !== exp_vec() || alerta_global !== 1'b0) begin
            bad++; $display("FAIL rel_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_ch1_persist();
        int temps [7] = '{260, 260, 170, 170, 170, 170, 170};
        int sts   [7] = '{S_ALTO, S_ALTO, S_BAJO, S_BAJO, S_BAJO, S_BAJO, S_ALERTA};
        for (int k = 0; k < 7; k++) begin
            step(NCH'(2), mk1(1, temps[k]), '0);
            total++;
            if (estado_actual[3:2] !== 2'(sts[k]) || alerta[1] !== (k == 6)) begin
                bad++; $display("FAIL ch1_persist k=%0d: got st=%0d al=%b want %0d %b", k, estado_actual[3:2], alerta[1], sts[k], k == 6);
            end
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL ch1_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ch2_swap();
        repeat (5) step(NCH'(4), mk1(2, 300), '0);
        total++;
        if (estado_actual[5:4] !== 2'(S_ALERTA) || ventilador[2] !== 1'b1 || calefactor[2] !== 1'b0) begin
            bad++; $display("FAIL ch2_hot: got st=%0d ven=%b cal=%b want 3 1 0", estado_actual[5:4], ventilador[2], calefactor[2]);
        end
        step(NCH'(4), mk1(2, 100), '0);
        total++;
        if (ventilador[2] !== 1'b0 || calefactor[2] !== 1'b1 || estado_actual[5:4] !== 2'(S_ALERTA)) begin
            bad++; $display("FAIL ch2_swap: got ven=%b cal=%b st=%0d want 0 1 3", ventilador[2], calefactor[2], estado_actual[5:4]);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL ch2_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) step(NCH'(8), mk1(3, 170), '0);
        #2 arst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++; $display("FAIL async_reset: got %h want 0", obs_vec());
        end
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
        step(NCH'(8), mk1(3, 170), '0);
        total++;
        if (estado_actual[7:6] !== 2'(S_BAJO)) begin
            bad++; $display("FAIL post_reset: got %0d want 1", estado_actual[7:6]);
        end
        repeat (3) step(NCH'(8), mk1(3, 170), '0);
        total++;
        if (estado_actual[7:6] !== 2'(S_BAJO) || alerta[3] !== 1'b0) begin
            bad++; $display("FAIL post_reset_cnt: got st=%0d al=%b want 1 0", estado_actual[7:6], alerta[3]);
        end
        step(NCH'(8), mk1(3, 170), '0);
        total++;
        if (estado_actual[7:6] !== 2'(S_ALERTA) || alerta[3] !== 1'b1) begin
            bad++; $display("FAIL post_reset_alert: got st=%0d al=%b want 3 1", estado_actual[7:6], alerta[3]);
        end
    endtask

    task automatic test_signed();
        step(NCH'(2), mk1(1, -50), '0);
        total++;
        if (estado_actual[3:2] !== 2'(S_BAJO)) begin
            bad++; $display("FAIL signed: got %0d want 1", estado_actual[3:2]);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL signed_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int edges [12] = '{179, 180, 184, 185, 245, 246, 250, 251, -50, -1024, 1023, 0};
        logic [NCH-1:0]   v, a;
        logic [NCH*W-1:0] t;
        int val;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                a[i] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 3) == 0) val = edges[$urandom_range(0, 11)];
                else val = int'($urandom_range(140, 290));
                t[i*W +: W] = W'(val);
            end
            step(v, t, a);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        arst_n = 1'b0;
        test_reset();
        test_ch0_alerta();
        test_ch0_release();
        test_ch1_persist();
        test_ch2_swap();
        test_reset_mid();
        test_signed();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/estado_temp_multi.md
ESTADO_TEMP_MULTI -- requirements
Module: estado_temp_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent temperature channels, 1..8.
REQ-002 Parameter W, default 11: signed temperature sample width.
REQ-003 Parameter TEMP_BAJO, default 180: low threshold; samples below it are "low".
REQ-004 Parameter TEMP_ALTO, default 250: high threshold; samples above it are "high".
REQ-005 Parameter HYST, default 5: hysteresis margin for returning to NORMAL.
REQ-006 Parameter N, default 5: consecutive out-of-range samples that trigger ALERTA; legal range 2..15.
REQ-007 clk  input  1  single system clock; all state updates on rising edge.
REQ-008 arst_n  input  1  asynchronous active-low reset.
REQ-009 temp_valid  input  NCH  per-channel sample strobe, one cycle per sample.
REQ-010 temp_in  input  NCH*W  per-channel signed samples packed; channel i at bits [i*W +: W].
REQ-011 ack_alerta  input  NCH  per-channel acknowledge clearing the sticky alert flag.
REQ-012 estado_actual  output  2*NCH  per-channel FSM state: NORMAL=00, BAJO=01, ALTO=10, ALERTA=11.
REQ-013 alerta  output  NCH  per-channel sticky alert flag.
REQ-014 calefactor  output  NCH  per-channel heater command.
REQ-015 ventilador  output  NCH  per-channel fan command.
REQ-016 alerta_global  output  1  registered OR of all alerta bits.

Function
REQ-017 Channels SHALL be fully independent; a channel changes state only on a cycle where its temp_valid=1.
REQ-018 Comparisons SHALL be signed, with thresholds sign-extended to W bits; samples in band [TEMP_BAJO+HYST, TEMP_ALTO-HYST] are "in-band".
REQ-019 Each channel SHALL keep a saturating persistence counter cnt, width clog2(N+1), holding consecutive same-direction out-of-range samples.
REQ-020 NORMAL: a low sample -> BAJO with cnt=1; a high sample -> ALTO with cnt=1; otherwise stay NORMAL with cnt=0.
REQ-021 BAJO: low sample -> cnt+1, and -> ALERTA when cnt+1==N; high sample -> ALTO with cnt=1; in-band -> NORMAL with cnt=0; hysteresis-zone sample -> hold state and cnt.
REQ-022 ALTO: mirror of REQ-021 with low/high exchanged.
REQ-023 ALERTA: in-band -> NORMAL with cnt=0; any other sample -> stay in ALERTA.
REQ-024 In ALERTA: a low sample sets calefactor=1, ventilador=0; a high sample sets ventilador=1, calefactor=0; a hysteresis-zone sample holds both.
REQ-025 Outside ALERTA: calefactor=0 and ventilador=0; both SHALL never be 1 simultaneously.
REQ-026 alerta[i] SHALL set on the edge that enters ALERTA and clear only on a cycle where ack_alerta[i]=1 while channel i is not in ALERTA; set wins over ack on the same edge.
REQ-027 Latency: a sample accepted on edge k SHALL be reflected in all outputs after edge k; alerta_global one edge later.
REQ-028 An illegal state encoding SHALL recover to NORMAL with cnt=0 and actuators off.

Reset
REQ-029 arst_n low SHALL immediately force every channel to NORMAL, cnt=0, and alerta, calefactor, ventilador, alerta_global to 0, including mid-persistence or mid-ALERTA.
REQ-030 The first sample accepted after reset deassertion SHALL be processed as from NORMAL.

Structure
REQ-031 Package temp_pkg SHALL hold the estado_t enum (NORMAL, BAJO, ALTO, ALERTA) and default threshold constants.
REQ-032 Per-channel logic SHALL be a sub-module estado_temp_canal, instantiated NCH times by generate; the top adds packing and alerta_global.
REQ-033 An elaboration check SHALL reject N<2, TEMP_BAJO+HYST > TEMP_ALTO-HYST, or NCH outside 1..8.

Verification
REQ-034 Ch0 five valid samples of 170 -> states BAJO,BAJO,BAJO,BAJO,ALERTA; calefactor[0]=1 after the fifth; other channels stay NORMAL.
REQ-035 Ch1 samples 260,260,170 -> ALTO, ALTO, then BAJO with cnt=1; no alert after 3 further 170 samples; alert on the 4th.
REQ-036 Ch0 in ALERTA, samples 182 then 200 -> holds ALERTA with calefactor=1, then NORMAL with actuators off; alerta[0] stays 1 until ack_alerta[0]=1.
REQ-037 Ch2 in ALERTA at 300, then sample 100 -> ventilador 1->0, calefactor 0->1 on the same edge.
REQ-038 Ch3 with 3 persistence samples, arst_n pulsed low mid-cycle -> all outputs 0 asynchronously; next 170 sample gives BAJO with cnt=1.
REQ-039 Signed check: sample -50 on any channel -> classified low, state BAJO.
